icache_fill_ctrl: RTL and testbench
===================================

# icache_fill_ctrl

Direct-mapped instruction-cache controller that sits between the instruction-fetch requester and the team's 128-byte `ram` model. It is the initiator of the RAM read protocol (`rden`/`addr`/`w_sel` out, `ready`/`data_out` in). A hit is served from internal tag/data arrays. A miss fills a 2-word (8-byte) line with two RAM read beats, then returns the requested word. Hit and miss events are counted for performance checks.

## Interface
- `LINES`, 8: number of cache lines, power of 2; IDX_W = log2(LINES).
- `CNT_W`, 16: width of the hit/miss counters.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_req`  in  1  fetch request; held with `cpu_addr` stable until `cpu_ready`.
- `cpu_addr`  in  32  byte address, word aligned (bits [1:0] ignored).
- `cpu_ready`  out  1  one-cycle pulse: `cpu_data` valid.
- `cpu_data`  out  32  fetched instruction word.
- `mem_rden`  out  1  RAM read enable, level, held until `mem_ready`.
- `mem_addr`  out  32  RAM line base address {tag, index, 3'b000}.
- `mem_w_sel`  out  1  word within line: 0 = bytes 0-3, 1 = bytes 4-7.
- `mem_ready`  in  1  RAM beat complete, sampled on rising edge.
- `mem_data`  in  32  RAM read data, valid when `mem_ready` = 1.
- `hit_cnt`  out  CNT_W  saturating hit count.
- `miss_cnt`  out  CNT_W  saturating miss count.

## Operation
- Address split: word select = addr[2]; index = addr[3+IDX_W-1:3]; tag = addr[31:3+IDX_W].
- Storage: per line a valid bit, a tag, and two 32-bit words.
- States: IDLE, HIT, FILL0, GAP, FILL1, RESP.
- **IDLE**
  - If `cpu_req` = 1, latch `cpu_addr`.
  - Hit (valid && tag match): latch selected word, go to HIT.
  - Miss: go to FILL0.
- **HIT**: `cpu_ready` = 1, `hit_cnt` +1, go to IDLE.
- **FILL0**
  - Drive `mem_rden` = 1, `mem_w_sel` = 0, `mem_addr` = line base.
  - On `mem_ready`: write `mem_data` to word 0, go to GAP.
- **GAP**: `mem_rden` = 0 for exactly one cycle. This gives the RAM a fresh rising edge on `rden` for the next beat. Go to FILL1.
- **FILL1**
  - Drive `mem_rden` = 1, `mem_w_sel` = 1, same `mem_addr`.
  - On `mem_ready`: write word 1, set the tag, set valid, go to RESP.
- **RESP**: `cpu_ready` = 1, `cpu_data` = word selected by the latched addr[2], `miss_cnt` +1, go to IDLE.
- `cpu_req` is ignored outside IDLE. No request is accepted in a cycle where `cpu_ready` = 1.
- A miss on a valid line overwrites it (no replacement choice, no write path).
- Counters saturate at 2^CNT_W−1 and never wrap.
- `mem_ready` outside FILL0/FILL1 is ignored.
- `mem_addr`/`mem_w_sel` are stable for the whole time `mem_rden` = 1.

## Timing
- Reset values: all valid bits = 0, state = IDLE. `cpu_ready`, `cpu_data`, `mem_rden`, `mem_addr`, `mem_w_sel`, `hit_cnt`, `miss_cnt` are all 0.
- Counting from cycle 0 = the IDLE cycle in which the request is sampled:
  - Hit: `cpu_ready` in cycle 1. Back-to-back hits sustain 1 word per 2 cycles.
  - Miss with RAM latency L (`mem_ready` in the L-th FILL cycle; L = 4 for the `ram` model):
    - FILL0: cycles 1..L.
    - GAP: cycle L+1.
    - FILL1: cycles L+2..2L+1.
    - `cpu_ready`: cycle 2L+2 (cycle 10 for L = 4).
- Reset mid-fill:
  - Next cycle: IDLE, `mem_rden` = 0.
  - The line being filled stays invalid (all lines are invalid after reset).
  - No `cpu_ready` is produced for the aborted request.
- `rst` and `cpu_req` in the same cycle: reset wins; the request is not accepted.

## Test plan
- Cold miss: reset, then request 0x0000_0004.
  - Required: FILL0 beat with `mem_addr` = 0x0, `mem_w_sel` = 0; then GAP with `mem_rden` low for one cycle; then beat with `mem_w_sel` = 1.
  - Required: `cpu_data` = 0x07060504 with `cpu_ready` in cycle 10; `miss_cnt` = 1.
- Hit after fill: request 0x0000_0000 → `cpu_data` = 0x03020100 in cycle 1; `mem_rden` stays 0; `hit_cnt` = 1.
- Conflict: request 0x40 (same index 0, different tag) → miss; `cpu_data` = 0x43424140. Then request 0x0 → miss again; `miss_cnt` increments each time.
- Reset mid-fill: assert `rst` in FILL1 cycle 2 of a miss.
  - Required: next cycle all outputs = 0, state IDLE.
  - Required: re-requesting the same address misses.
- Stretched memory, L = 7 (bench responder): `cpu_ready` in cycle 16. `mem_addr`/`mem_w_sel` are unchanged while `mem_rden` is high. A spurious `mem_ready` in IDLE has no effect.
- Saturation with CNT_W = 4: 20 consecutive hits → `hit_cnt` = 15, with no wrap to 0.

Source files
------------

// File: rtl/icache_fill_ctrl_if.sv
// Bus bundle between the fetch requester, the cache fill controller and the RAM.
// master: the cache controller (answers fetches, initiates RAM reads).
// slave:  the environment (issues fetches, answers RAM beats).
interface icache_fill_ctrl_if;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        cpu_ready;
  logic [31:0] cpu_data;
  logic        mem_rden;
  logic [31:0] mem_addr;
  logic        mem_w_sel;
  logic        mem_ready;
  logic [31:0] mem_data;

  modport master (
    input  cpu_req, cpu_addr, mem_ready, mem_data,
    output cpu_ready, cpu_data, mem_rden, mem_addr, mem_w_sel
  );

  modport slave (
    output cpu_req, cpu_addr, mem_ready, mem_data,
    input  cpu_ready, cpu_data, mem_rden, mem_addr, mem_w_sel
  );
endinterface

// File: rtl/icache_fill_ctrl.sv
// Direct-mapped instruction cache with 2-word lines. Hits are answered from the
// local tag/data arrays; misses fetch both words of the line from RAM with two
// read beats separated by one idle cycle, then return the requested word.
module icache_fill_ctrl #(
  parameter int LINES = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  icache_fill_ctrl_if.master bus,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [CNT_W-1:0]   miss_cnt
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 32 - 3 - IDX_W;

  typedef enum logic [2:0] {IDLE, HIT, FILL0, GAP, FILL1, RESP} state_t;

  state_t            state_reg, state_next;
  logic [31:0]       addr_reg;
  logic [31:0]       data_reg;
  logic [LINES-1:0]  valid_reg;

  logic [TAG_W-1:0]  tag_mem   [LINES];
  logic [31:0]       word0_mem [LINES];
  logic [31:0]       word1_mem [LINES];

  logic [IDX_W-1:0]  req_idx, fill_idx;
  logic [TAG_W-1:0]  req_tag, fill_tag;
  logic              lookup_hit;
  logic              accept;
  logic              beat0_done, beat1_done;

  // The lookup is combinational so a hit can be answered in the very next cycle.
  assign req_idx    = bus.cpu_addr[3 +: IDX_W];
  assign req_tag    = bus.cpu_addr[31 : 3+IDX_W];
  assign fill_idx   = addr_reg[3 +: IDX_W];
  assign fill_tag   = addr_reg[31 : 3+IDX_W];
  assign lookup_hit = valid_reg[req_idx] && (tag_mem[req_idx] == req_tag);
  assign accept     = (state_reg == IDLE) && bus.cpu_req;
  assign beat0_done = (state_reg == FILL0) && bus.mem_ready;
  assign beat1_done = (state_reg == FILL1) && bus.mem_ready;

  // State register; reset aborts any fill in progress.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and Moore outputs; all bus outputs derive from registered state.
  always_comb begin
    state_next    = state_reg;
    bus.cpu_ready = 1'b0;
    bus.cpu_data  = data_reg;
    bus.mem_rden  = 1'b0;
    bus.mem_w_sel = 1'b0;
    bus.mem_addr  = {addr_reg[31:3], 3'b000};
    case (state_reg)
      IDLE: begin
        if (bus.cpu_req) state_next = lookup_hit ? HIT : FILL0;
      end
      HIT: begin
        bus.cpu_ready = 1'b1;
        state_next    = IDLE;
      end
      FILL0: begin
        bus.mem_rden = 1'b1;
        if (bus.mem_ready) state_next = GAP;
      end
      GAP: begin
        state_next = FILL1;
      end
      FILL1: begin
        bus.mem_rden  = 1'b1;
        bus.mem_w_sel = 1'b1;
        if (bus.mem_ready) state_next = RESP;
      end
      RESP: begin
        bus.cpu_ready = 1'b1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request address latch and returned-word capture (hit word or matching fill beat).
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg <= '0;
      data_reg <= '0;
    end else begin
      if (accept) begin
        addr_reg <= bus.cpu_addr;
        if (lookup_hit)
          data_reg <= bus.cpu_addr[2] ? word1_mem[req_idx] : word0_mem[req_idx];
      end
      if (beat0_done && !addr_reg[2]) data_reg <= bus.mem_data;
      if (beat1_done &&  addr_reg[2]) data_reg <= bus.mem_data;
    end
  end

  // Line storage; contents only matter once the valid bit is set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (beat0_done) word0_mem[fill_idx] <= bus.mem_data;
      if (beat1_done) begin
        word1_mem[fill_idx] <= bus.mem_data;
        tag_mem[fill_idx]   <= fill_tag;
      end
    end
  end

  // Per-line valid bits: dropped when a miss starts refilling the line, set on the last beat.
  generate
    for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
      always_ff @(posedge clk) begin
        if (rst)
          valid_reg[gi] <= 1'b0;
        else if (accept && !lookup_hit && (req_idx == IDX_W'(gi)))
          valid_reg[gi] <= 1'b0;
        else if (beat1_done && (fill_idx == IDX_W'(gi)))
          valid_reg[gi] <= 1'b1;
      end
    end
  endgenerate

  // Saturating hit counter, bumped while the hit response is presented.
  always_ff @(posedge clk) begin
    if (rst)
      hit_cnt <= '0;
    else if ((state_reg == HIT) && (hit_cnt != {CNT_W{1'b1}}))
      hit_cnt <= hit_cnt + 1'b1;
  end

  // Saturating miss counter, bumped while the miss response is presented.
  always_ff @(posedge clk) begin
    if (rst)
      miss_cnt <= '0;
    else if ((state_reg == RESP) && (miss_cnt != {CNT_W{1'b1}}))
      miss_cnt <= miss_cnt + 1'b1;
  end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Bench for icache_fill_ctrl: directed fetches, a latency-programmable RAM
// responder, and a scoreboard monitor checking every cpu_ready pulse.
module tb_icache_fill_ctrl;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  icache_fill_ctrl_if bus();

  icache_fill_ctrl #(.LINES(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   total = 0;
  int   bad   = 0;
  int   c0    = 0;
  int   lat   = 4;
  logic spur  = 1'b0;

  typedef struct { logic [31:0] data; int cyc; } exp_t;
  typedef struct { int off; logic [31:0] addr; logic wsel; } beat_t;
  exp_t  sb[$];
  beat_t beats[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // RAM contents: byte at address a holds a[7:0].
  function automatic logic [31:0] ram_word(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  // RAM responder: mem_ready in the lat-th cycle of each rden-high beat.
  int          bcnt = 0;
  logic [31:0] hold_addr;
  logic        hold_wsel;
  always @(negedge clk) begin
    if (bus.mem_rden) begin
      if (bcnt == 0) begin
        beats.push_back('{cyc - c0, bus.mem_addr, bus.mem_w_sel});
        hold_addr = bus.mem_addr;
        hold_wsel = bus.mem_w_sel;
      end else begin
        chk("mem_addr_stable", bus.mem_addr, hold_addr);
        chk("mem_w_sel_stable", {31'b0, bus.mem_w_sel}, {31'b0, hold_wsel});
      end
      bcnt++;
      if (bcnt == lat) begin
        bus.mem_ready = 1'b1;
        bus.mem_data  = ram_word(bus.mem_addr + (bus.mem_w_sel ? 32'd4 : 32'd0));
      end else begin
        bus.mem_ready = 1'b0;
        bus.mem_data  = 32'h0;
      end
    end else begin
      bcnt          = 0;
      bus.mem_ready = spur;
      bus.mem_data  = spur ? 32'hDEAD_BEEF : 32'h0;
    end
  end

  // Scoreboard monitor: each cpu_ready pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.cpu_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_cpu_ready: got pulse at cycle %0d want none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("cpu_data", bus.cpu_data, e.data);
        chk("ready_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int off);
    int n;
    n = 0;
    @(posedge clk); #1;
    c0 = cyc;
    beats.delete();
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = addr;
    sb.push_back('{data, c0 + off});
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cpu_ready && n < 40);
    if (!bus.cpu_ready) begin
      total++;
      bad++;
      $display("FAIL fetch_timeout: got no cpu_ready want one for addr %h", addr);
      sb.delete();
    end
    $display("txn addr=%h data=%h offset=%0d hit=%0d miss=%0d",
             addr, bus.cpu_data, cyc - c0, hit_cnt, miss_cnt);
    bus.cpu_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic chk_fill_beats(input logic [31:0] base, input int l);
    chk("beat_count", 32'(beats.size()), 32'd2);
    if (beats.size() == 2) begin
      chk("beat0_offset", 32'(beats[0].off), 32'd1);
      chk("beat0_addr", beats[0].addr, base);
      chk("beat0_wsel", {31'b0, beats[0].wsel}, 32'd0);
      chk("beat1_offset", 32'(beats[1].off), 32'(l + 2));
      chk("beat1_addr", beats[1].addr, base);
      chk("beat1_wsel", {31'b0, beats[1].wsel}, 32'd1);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cpu_ready"}, {31'b0, bus.cpu_ready}, 32'd0);
    chk({tag, "_cpu_data"}, bus.cpu_data, 32'd0);
    chk({tag, "_mem_rden"}, {31'b0, bus.mem_rden}, 32'd0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
    chk({tag, "_mem_w_sel"}, {31'b0, bus.mem_w_sel}, 32'd0);
    chk({tag, "_hit_cnt"}, 32'(hit_cnt), 32'd0);
    chk({tag, "_miss_cnt"}, 32'(miss_cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_hits;
    rst          = 1'b1;
    bus.cpu_req  = 1'b0;
    bus.cpu_addr = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    // Request coincident with reset must not be accepted.
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h4;
    @(posedge clk); #1;
    rst         = 1'b0;
    bus.cpu_req = 1'b0;
    chk_all_zero("reset");

    // Cold miss on 0x4.
    fetch(32'h0000_0004, 32'h0706_0504, 10);
    chk_fill_beats(32'h0, 4);
    chk("cold_miss_cnt", 32'(miss_cnt), 32'd1);

    // Hit on the other word of the same line.
    fetch(32'h0000_0000, 32'h0302_0100, 1);
    chk("hit_no_beats", 32'(beats.size()), 32'd0);
    chk("hit_cnt_1", 32'(hit_cnt), 32'd1);

    // Conflict misses on index 0.
    fetch(32'h0000_0040, 32'h4342_4140, 10);
    chk_fill_beats(32'h40, 4);
    chk("conflict_miss_cnt_2", 32'(miss_cnt), 32'd2);
    fetch(32'h0000_0000, 32'h0302_0100, 10);
    chk("conflict_miss_cnt_3", 32'(miss_cnt), 32'd3);

    // Reset in FILL1 cycle 2 of a miss on 0x80, with cpu_req still high.
    @(posedge clk); #1;
    c0           = cyc;
    beats.delete();
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h0000_0080;
    repeat (7) @(posedge clk);
    #1;
    chk("midfill_rden", {31'b0, bus.mem_rden}, 32'd1);
    chk("midfill_wsel", {31'b0, bus.mem_w_sel}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("midfill");
    rst         = 1'b0;
    bus.cpu_req = 1'b0;
    $display("txn addr=00000080 aborted by reset at offset 7");
    fetch(32'h0000_0080, 32'h8382_8180, 10);
    chk_fill_beats(32'h80, 4);
    chk("refetch_miss_cnt", 32'(miss_cnt), 32'd1);
    chk("refetch_hit_cnt", 32'(hit_cnt), 32'd0);

    // Stretched RAM latency.
    lat = 7;
    fetch(32'h0000_001C, 32'h1F1E_1D1C, 16);
    chk_fill_beats(32'h18, 7);
    chk("slow_miss_cnt", 32'(miss_cnt), 32'd2);

    // Spurious mem_ready while idle.
    spur = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    spur = 1'b0;
    chk("spur_rden", {31'b0, bus.mem_rden}, 32'd0);
    chk("spur_hit_cnt", 32'(hit_cnt), 32'd0);
    chk("spur_miss_cnt", 32'(miss_cnt), 32'd2);
    fetch(32'h0000_0018, 32'h1B1A_1918, 1);
    chk("spur_then_hit_cnt", 32'(hit_cnt), 32'd1);

    // Hit counter saturation.
    exp_hits = 1;
    for (int i = 0; i < 20; i++) begin
      fetch(32'h0000_001C, 32'h1F1E_1D1C, 1);
      if (exp_hits < 15) exp_hits++;
      chk("sat_hit_cnt", 32'(hit_cnt), 32'(exp_hits));
    end
    chk("sat_final_hit_cnt", 32'(hit_cnt), 32'd15);
    chk("sat_miss_cnt", 32'(miss_cnt), 32'd2);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
